io_uart_responder: RTL and testbench

//   Memory-mapped IO responder for the RV32 core's load/store bus: owns the LED register and a

---
 rtl/io_map_pkg.sv | 22 ++
 rtl/uart_tx_core.sv | 92 +++++++++
 rtl/io_uart_responder.sv | 108 ++++++++++
 tb/tb_io_uart_responder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// Shared IO-page map for the RV32 SOC: page select bit, register offsets,
// STATUS bit positions and the UART transmit FSM state encoding.
package io_map_pkg;

  localparam int IO_PAGE_BIT = 22;

  localparam logic [5:0] REG_LEDS   = 6'd0;
  localparam logic [5:0] REG_TXDATA = 6'd1;
  localparam logic [5:0] REG_STATUS = 6'd2;

  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF  = 2;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serialiser: baud down-counter, shift register and frame FSM, registered txd.
//   state    | meaning
//   TX_IDLE  | line high, ready; start pulse loads byte_in
//   TX_START | start bit (low) for DIV clocks
//   TX_DATA  | 8 data bits, LSB first, DIV clocks each
//   TX_STOP  | stop bit (high) for DIV clocks
module uart_tx_core
  import io_map_pkg::*;
#(
  parameter int DIV = 104
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] byte_in,
  input  logic       start,
  output logic       ready,
  output logic       txd
);

  localparam int             CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  CNT_TOP = CW'(DIV - 1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  tx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          txd_q;
  logic          bit_end;

  assign bit_end = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: begin
          txd_q <= 1'b1;
          if (start) begin
            shift_q <= byte_in;
            cnt_q   <= CNT_TOP;
            txd_q   <= 1'b0;
            state_q <= TX_START;
          end
        end
        TX_START: begin
          if (bit_end) begin
            cnt_q   <= CNT_TOP;
            bit_q   <= '0;
            txd_q   <= shift_q[0];
            state_q <= TX_DATA;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            cnt_q <= CNT_TOP;
            if (bit_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= TX_STOP;
            end else begin
              // next bit is shift_q[1], visible on the line as the shift lands
              shift_q <= shift_q >> 1;
              txd_q   <= shift_q[1];
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            state_q <= TX_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign ready = (state_q == TX_IDLE);
  assign txd   = txd_q;

endmodule

// File: rtl/io_uart_responder.sv
// IO-page responder for the RV32 load/store bus: LED register, TX byte FIFO
// with sticky overflow, STATUS register, and the UART transmitter.
module io_uart_responder
  import io_map_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12_000_000,
  parameter int BAUD        = 115_200,
  parameter int FIFO_DEPTH  = 4,
  parameter int LED_W       = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wmask,
  input  logic             mem_rstrb,
  output logic [31:0]      mem_rdata,
  output logic [LED_W-1:0] leds,
  output logic             txd
);

  localparam int           DIV     = CLK_FREQ_HZ / BAUD;
  localparam int           AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]  PTR_ONE = (AW + 1)'(1);

  logic [LED_W-1:0] leds_q;
  logic [31:0]      rdata_q;
  logic             ovf_q;
  logic [AW:0]      wptr_q, rptr_q;
  logic [7:0]       fifo_q [FIFO_DEPTH];

  logic        io_sel, wr_any;
  logic [5:0]  reg_off;
  logic        led_we, push, pop, push_ok, rd_status, ovf_set;
  logic        empty, full, tx_ready;
  logic [31:0] status, rd_val;
  logic        unused_bits;

  assign io_sel    = mem_addr[IO_PAGE_BIT];
  assign reg_off   = mem_addr[7:2];
  assign wr_any    = |mem_wmask;
  assign led_we    = io_sel && wr_any && (reg_off == REG_LEDS);
  assign push      = io_sel && mem_wmask[0] && (reg_off == REG_TXDATA);
  assign rd_status = io_sel && mem_rstrb && (reg_off == REG_STATUS);

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = tx_ready && !empty;
  // a pop in the same cycle frees the slot the full-FIFO push lands in
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_comb begin
    status          = '0;
    status[ST_BUSY] = !empty || !tx_ready;
    status[ST_FULL] = full;
    status[ST_OVF]  = ovf_q;
  end

  always_comb begin
    rd_val = '0;
    if (io_sel) begin
      case (reg_off)
        REG_LEDS:   rd_val[LED_W-1:0] = leds_q;
        REG_STATUS: rd_val = status;
        default:    rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      leds_q  <= '0;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      if (led_we)    leds_q  <= mem_wdata[LED_W-1:0];
      if (mem_rstrb) rdata_q <= rd_val;
      if (push_ok)   wptr_q  <= wptr_q + PTR_ONE;
      if (pop)       rptr_q  <= rptr_q + PTR_ONE;
      ovf_q <= ovf_set || (ovf_q && !rd_status);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wptr_q[AW-1:0]] <= mem_wdata[7:0];
  end

  uart_tx_core #(
    .DIV (DIV)
  ) u_tx (
    .clk     (clk),
    .resetn  (resetn),
    .byte_in (fifo_q[rptr_q[AW-1:0]]),
    .start   (pop),
    .ready   (tx_ready),
    .txd     (txd)
  );

  assign mem_rdata = rdata_q;
  assign leds      = leds_q;

  assign unused_bits = ^{mem_addr[31:IO_PAGE_BIT+1], mem_addr[IO_PAGE_BIT-1:8],
                         mem_addr[1:0], mem_wdata[31:8]};

endmodule

// File: tb/tb_io_uart_responder.sv
// Directed bench for io_uart_responder at DIV=10: bus register access, UART
// framing and timing, FIFO full/overflow corners, mid-frame reset, decode holes.
module tb_io_uart_responder;

  localparam logic [31:0] IO = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wmask = '0;
  logic        mem_rstrb = 1'b0;
  logic [31:0] mem_rdata;
  logic [4:0]  leds;
  logic        txd;

  int vec_cnt = 0;
  int err_cnt = 0;
  int rx_ferr = 0;
  logic [7:0] rx_q[$];

  io_uart_responder #(
    .CLK_FREQ_HZ (1_000_000),
    .BAUD        (100_000),
    .FIFO_DEPTH  (4),
    .LED_W       (5)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rstrb (mem_rstrb),
    .mem_rdata (mem_rdata),
    .leds      (leds),
    .txd       (txd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] io_reg(input int off);
    return IO | 32'(off * 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // callers sit on a negedge; strobe is seen by exactly one posedge
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    mem_addr  = a;
    mem_wdata = d;
    mem_wmask = m;
    @(negedge clk);
    mem_wmask = '0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    mem_addr  = a;
    mem_rstrb = 1'b1;
    @(negedge clk);
    mem_rstrb = 1'b0;
    d = mem_rdata;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
  endtask

  // line receiver: sample mid-bit, 10 clocks per bit
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (resetn && txd === 1'b0) begin
        repeat (5) @(negedge clk);
        if (txd !== 1'b0) rx_ferr++;
        for (int k = 0; k < 8; k++) begin
          repeat (10) @(negedge clk);
          b[k] = txd;
        end
        repeat (10) @(negedge clk);
        if (txd !== 1'b1) rx_ferr++;
        rx_q.push_back(b);
      end
    end
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  b55;
    logic [7:0]  exp5 [5];
    logic [7:0]  exp6 [6];
    int          bad;

    b55  = 8'h55;
    exp5 = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    exp6 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h16};

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_txd", 32'(txd), 32'h1);
    chk("rst_rdata", mem_rdata, 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    bus_rd(io_reg(2), rd);
    chk("rst_status", rd, 32'h0);

    bus_wr(io_reg(0), 32'h1F, 4'hF);
    chk("leds_wr", 32'(leds), 32'h1F);
    bus_rd(io_reg(0), rd);
    chk("leds_rd", rd, 32'h1F);

    // single 0x55 frame, bit-exact waveform
    rx_q.delete();
    bus_wr(io_reg(1), 32'h55, 4'h1);
    bad = 0;
    fork
      begin
        logic e;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (i < 10)       e = 1'b0;
          else if (i >= 90) e = 1'b1;
          else              e = b55[(i / 10) - 1];
          if (txd !== e) bad++;
        end
      end
      begin
        logic [31:0] r;
        repeat (40) @(negedge clk);
        bus_rd(io_reg(2), r);
        chk("status_busy", r, 32'h1);
      end
    join
    chk("txd_wave_55", 32'(bad), 32'h0);
    bus_rd(io_reg(2), rd);
    chk("status_stop_bit", rd, 32'h1);
    bus_rd(io_reg(2), rd);
    chk("status_idle", rd, 32'h0);
    chk("rx_55_count", 32'(rx_q.size()), 32'h1);
    if (rx_q.size() > 0) chk("rx_55", 32'(rx_q[0]), 32'h55);

    // five back-to-back pushes fill the FIFO without overflow
    rx_q.delete();
    for (int i = 0; i < 5; i++) bus_wr(io_reg(1), 32'h41 + 32'(i), 4'h1);
    bus_rd(io_reg(2), rd);
    chk("status_5push", rd, 32'h3);
    wait_rx(5, 700);
    chk("rx5_count", 32'(rx_q.size()), 32'h5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++)
      chk($sformatf("rx5_%0d", i), 32'(rx_q[i]), 32'(exp5[i]));
    chk("rx_framing", 32'(rx_ferr), 32'h0);
    repeat (10) @(negedge clk);
    bus_rd(io_reg(2), rd);
    chk("status_5done", rd, 32'h0);

    // six pushes: sixth dropped; later push on a pop cycle is accepted
    rx_q.delete();
    for (int i = 0; i < 6; i++) bus_wr(io_reg(1), 32'h10 + 32'(i), 4'h1);
    bus_rd(io_reg(2), rd);
    chk("status_ovf", rd, 32'h7);
    bus_rd(io_reg(2), rd);
    chk("status_ovf_clr", rd, 32'h3);
    repeat (94) @(negedge clk);
    bus_wr(io_reg(1), 32'h16, 4'h1);
    bus_rd(io_reg(2), rd);
    chk("status_push_pop_full", rd, 32'h3);
    wait_rx(6, 800);
    repeat (150) @(negedge clk);
    chk("rx6_count", 32'(rx_q.size()), 32'h6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++)
      chk($sformatf("rx6_%0d", i), 32'(rx_q[i]), 32'(exp6[i]));

    // reset at clock 35 of a frame with another byte still queued
    rx_q.delete();
    bus_wr(io_reg(1), 32'h00, 4'h1);
    bus_wr(io_reg(1), 32'h00, 4'h1);
    repeat (33) @(negedge clk);
    chk("txd_mid_frame", 32'(txd), 32'h0);
    resetn = 1'b0;
    @(negedge clk);
    chk("txd_on_reset", 32'(txd), 32'h1);
    chk("leds_on_reset", 32'(leds), 32'h0);
    chk("rdata_on_reset", mem_rdata, 32'h0);
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    chk("txd_no_glitch", 32'(bad), 32'h0);
    bus_rd(io_reg(2), rd);
    chk("status_after_rst", rd, 32'h0);
    rx_q.delete();

    // decode holes: non-IO page and unmapped offsets
    bus_wr(io_reg(0), 32'h0A, 4'hF);
    bus_wr(32'h0000_0000, 32'h1F, 4'hF);
    bus_wr(io_reg(5), 32'h1F, 4'hF);
    chk("leds_hole_wr", 32'(leds), 32'h0A);
    bus_wr(32'h0000_0004, 32'h77, 4'h1);
    bus_wr(io_reg(5), 32'h77, 4'h1);
    bus_wr(io_reg(1), 32'h77, 4'h2);
    bus_rd(io_reg(2), rd);
    chk("status_no_push", rd, 32'h0);
    bus_rd(io_reg(0), rd);
    chk("leds_rd2", rd, 32'h0A);
    bus_rd(32'h0000_0000, rd);
    chk("rd_nonio", rd, 32'h0);
    bus_rd(io_reg(0), rd);
    bus_rd(io_reg(5), rd);
    chk("rd_off5", rd, 32'h0);
    bus_rd(io_reg(0), rd);
    bus_rd(io_reg(1), rd);
    chk("rd_txdata", rd, 32'h0);

    // write and read of LEDS in the same cycle returns the old value
    mem_addr  = io_reg(0);
    mem_wdata = 32'h11;
    mem_wmask = 4'hF;
    mem_rstrb = 1'b1;
    @(negedge clk);
    mem_wmask = '0;
    mem_rstrb = 1'b0;
    chk("rd_pre_wr", mem_rdata, 32'h0A);
    chk("leds_post_wr", 32'(leds), 32'h11);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
